// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - handshaked multi-cycle load/store responder over a word-organised RAM
// One request in flight; byte-lane stores, sign/zero-extended loads, error response on bad requests.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_mask_type,
    input  logic        req_ext_type,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_CYCLES);
    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t state, state_next;

    logic [3:0]    wait_cnt;
    logic          lat_we;
    logic          lat_ext;
    logic [1:0]    lat_mask;
    logic [AW+1:0] lat_addr;
    logic [31:0]   lat_wdata;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          handshake;
    logic          req_err;
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;
    logic [3:0]    st_be;
    logic [31:0]   st_data;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign handshake = req_valid && req_ready;

    // Checked on the live inputs at the handshake edge, which is the same value that gets latched.
    always_comb begin
        req_err = (req_mask_type == 2'b11)
               || (req_mask_type == 2'b01 && req_addr[0])
               || (req_mask_type == 2'b10 && req_addr[1:0] != 2'b00)
               || ({2'b00, req_addr[31:2]} >= DEPTH_LIMIT);
    end

    assign widx    = lat_addr[AW+1:2];
    assign lane    = lat_addr[1:0];
    assign rd_word = mem[widx];

    always_comb begin
        ld_byte = rd_word[7:0];
        case (lane)
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            2'd3:    ld_byte = rd_word[31:24];
            default: ld_byte = rd_word[7:0];
        endcase
        ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

        case (lat_mask)
            2'b00:   ld_data = lat_ext ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = lat_ext ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = rd_word;
        endcase

        // Replicated data lets the byte enables alone pick the lanes.
        case (lat_mask)
            2'b00: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{lat_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = lat_wdata;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    if (req_err)
                        state_next = ST_RESP;
                    else if (WAIT_INIT == 4'd0)
                        state_next = ST_ACCESS;
                    else
                        state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt <= 4'd1)
                    state_next = ST_ACCESS;
            end
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            lat_we    <= 1'b0;
            lat_ext   <= 1'b0;
            lat_mask  <= 2'b00;
            lat_addr  <= '0;
            lat_wdata <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        lat_we    <= req_we;
                        lat_ext   <= req_ext_type;
                        lat_mask  <= req_mask_type;
                        lat_addr  <= req_addr[AW+1:0];
                        lat_wdata <= req_wdata;
                        wait_cnt  <= WAIT_INIT;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= req_err;
                    end
                end
                ST_WAIT: wait_cnt <= wait_cnt - 4'd1;
                ST_ACCESS: begin
                    rsp_rdata <= lat_we ? 32'd0 : ld_data;
                    rsp_err   <= 1'b0;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM is not reset; a reset coinciding with the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (state == ST_ACCESS && lat_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b])
                    mem[widx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized bench with a byte-addressed reference model
// Two instances (2 and 0 wait states) share stimulus; sel picks the active one.
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [1:0]  req_mask_type = 2'b00;
    logic        req_ext_type = 1'b0;
    logic        rsp_ready = 1'b1;

    logic        rr2, rv2, re2, rr0, rv0, re0;
    logic [31:0] rd2, rd0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rr2),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_mask_type(req_mask_type), .req_ext_type(req_ext_type),
        .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(re2)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rr0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_mask_type(req_mask_type), .req_ext_type(req_ext_type),
        .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(re0)
    );

    assign req_ready = sel ? rr0 : rr2;
    assign rsp_valid = sel ? rv0 : rv2;
    assign rsp_rdata = sel ? rd0 : rd2;
    assign rsp_err   = sel ? re0 : re2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  mb [2][4*DEPTH];
    bit          active = 1'b0;
    int          exp_start = 0;
    logic [31:0] exp_rdata = 32'd0;
    bit          exp_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Byte-addressed memory: a request touches 1<<mask consecutive bytes, little-endian.
    function automatic void model(input int s, input bit we, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [1:0] m, input bit ext,
                                  output bit err, output logic [31:0] rd);
        int n;
        logic [31:0] v;
        rd  = 32'd0;
        err = (m == 2'b11) || (m == 2'b01 && a % 2 != 0) || (m == 2'b10 && a % 4 != 0)
              || (a / 4 >= DEPTH);
        if (err) return;
        n = 1 << m;
        if (we) begin
            for (int i = 0; i < n; i++) mb[s][int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(mb[s][int'(a) + i]) << (8*i));
            if (n < 4 && !ext && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rd = v;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("req_ready", 32'(req_ready), 32'(!active));
            check("rsp_valid", 32'(rsp_valid), 32'(active && cyc >= exp_start));
            if (active && cyc >= exp_start) begin
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
        end
    end

    task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] m, input bit ext, input int hold, input bit pulse,
                       output logic [31:0] got, output bit got_err,
                       output logic [31:0] mexp, output bit merr, output int hs);
        int w;
        w = sel ? 0 : 2;
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = wd; req_mask_type = m; req_ext_type = ext;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        hs = cyc;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_mask_type = 2'($urandom); req_ext_type = 1'($urandom);
        model(int'(sel), we, a, wd, m, ext, merr, mexp);
        exp_rdata = mexp;
        exp_err   = merr;
        exp_start = hs + (merr ? 0 : w + 1);
        active    = 1'b1;
        if (hold > 0) rsp_ready = 1'b0;
        while (cyc < exp_start + hold) begin
            req_valid = pulse && (cyc == exp_start + 1);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        got     = rsp_rdata;
        got_err = rsp_err;
        @(posedge clk); #1;
        active = 1'b0;
    endtask

    task automatic init_words(input int n);
        logic [31:0] g, e;
        bit ge, me;
        int h;
        for (int i = 0; i < n; i++) txn(1'b1, 32'(4*i), 32'd0, 2'b10, 1'b0, 0, 1'b0, g, ge, e, me, h);
    endtask

    task automatic random_txns(input int n);
        logic [31:0] g, e, a;
        bit ge, me;
        int h, r;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 32'(4*DEPTH) + $urandom_range(0, 63);
            else if (r == 1) a = $urandom | 32'h8000_0000;
            else             a = $urandom_range(0, 63);
            txn(1'($urandom), a, $urandom, 2'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)), 1'b0, g, ge, e, me, h);
        end
    endtask

    initial begin
        logic [31:0] g, e;
        bit ge, me;
        int h, hprev;

        #1 rst = 1'b1;
        #1;
        sel = 1'b0;
        #1;
        check("reset req_ready w2", 32'(req_ready), 32'd1);
        check("reset rsp_valid w2", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata w2", rsp_rdata, 32'd0);
        check("reset rsp_err w2", 32'(rsp_err), 32'd0);
        sel = 1'b1;
        #1;
        check("reset req_ready w0", 32'(req_ready), 32'd1);
        check("reset rsp_valid w0", 32'(rsp_valid), 32'd0);
        sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        init_words(16);
        txn(1'b1, 32'h40, 32'hA5A5_A5A5, 2'b10, 1'b0, 0, 1'b0, g, ge, e, me, h);

        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, 1'b0, g, ge, e, me, h);
        check("store word err", 32'(ge), 32'd0);
        txn(1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 0, 1'b0, g, ge, e, me, h);
        check("load word 0x10", g, 32'hDEAD_BEEF);
        check("model word 0x10", e, 32'hDEAD_BEEF);

        txn(1'b1, 32'h23, 32'h0000_0080, 2'b00, 1'b0, 0, 1'b0, g, ge, e, me, h);
        txn(1'b1, 32'h20, 32'h0000_FFFF, 2'b01, 1'b0, 0, 1'b0, g, ge, e, me, h);
        txn(1'b0, 32'h23, 32'd0, 2'b00, 1'b0, 0, 1'b0, g, ge, e, me, h);
        check("lb 0x23", g, 32'hFFFF_FF80);
        check("model lb 0x23", e, 32'hFFFF_FF80);
        txn(1'b0, 32'h23, 32'd0, 2'b00, 1'b1, 0, 1'b0, g, ge, e, me, h);
        check("lbu 0x23", g, 32'h0000_0080);
        txn(1'b0, 32'h20, 32'd0, 2'b01, 1'b1, 0, 1'b0, g, ge, e, me, h);
        check("lhu 0x20", g, 32'h0000_FFFF);
        txn(1'b0, 32'h20, 32'd0, 2'b10, 1'b0, 0, 1'b0, g, ge, e, me, h);
        check("lw 0x20", g, 32'h8000_FFFF);

        txn(1'b0, 32'h21, 32'd0, 2'b01, 1'b0, 0, 1'b0, g, ge, e, me, h);
        check("lh 0x21 err", 32'(ge), 32'd1);
        check("lh 0x21 rdata", g, 32'd0);
        check("model lh 0x21 err", 32'(me), 32'd1);
        txn(1'b0, 32'h8, 32'd0, 2'b11, 1'b0, 0, 1'b0, g, ge, e, me, h);
        check("mask 11 err", 32'(ge), 32'd1);
        txn(1'b1, 32'h2, 32'hFFFF_FFFF, 2'b10, 1'b0, 0, 1'b0, g, ge, e, me, h);
        check("sw 0x2 err", 32'(ge), 32'd1);
        txn(1'b0, 32'h0, 32'd0, 2'b10, 1'b0, 0, 1'b0, g, ge, e, me, h);
        check("lw 0x0 unchanged", g, 32'd0);
        txn(1'b0, 32'(4*DEPTH), 32'd0, 2'b10, 1'b0, 0, 1'b0, g, ge, e, me, h);
        check("out of range err", 32'(ge), 32'd1);

        txn(1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 5, 1'b1, g, ge, e, me, h);
        check("backpressure lw", g, 32'hDEAD_BEEF);
        txn(1'b0, 32'h22, 32'd0, 2'b01, 1'b0, 0, 1'b0, g, ge, e, me, h);
        check("lh 0x22 after bp", g, 32'hFFFF_8000);

        random_txns(120);

        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h1234_5678;
        req_mask_type = 2'b10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        active = 1'b1;
        exp_start = cyc + 1000;
        @(posedge clk); #1;
        rst = 1'b1;
        active = 1'b0;
        #1;
        check("midreset req_ready", 32'(req_ready), 32'd1);
        check("midreset rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset rsp_rdata", rsp_rdata, 32'd0);
        check("midreset rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        txn(1'b0, 32'h40, 32'd0, 2'b10, 1'b0, 0, 1'b0, g, ge, e, me, h);
        check("lw 0x40 after reset", g, 32'hA5A5_A5A5);

        sel = 1'b1;
        init_words(16);
        txn(1'b1, 32'h4, 32'hCAFE_F00D, 2'b10, 1'b0, 0, 1'b0, g, ge, e, me, hprev);
        for (int i = 0; i < 4; i++) begin
            txn(1'b0, 32'h4, 32'd0, 2'b10, 1'b0, 0, 1'b0, g, ge, e, me, h);
            check("w0 lw 0x4", g, 32'hCAFE_F00D);
            check("w0 back-to-back period", 32'(h - hprev), 32'd3);
            hprev = h;
        end
        random_txns(120);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
